// File: rtl/week_4_encoder_registered.sv
// Registered 4-to-2 priority encoder with a valid/ready handshake on both sides.
// One-cycle latency and full throughput; a saturating counter tracks codes that were not one-hot.
module week_4_encoder_registered #(
    parameter int N_IN      = 4,
    parameter int SEL_W     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN-1:0]      in_code,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] enc_sel;
    logic             enc_err;
    logic             accept;

    // Ascending scan so the highest set bit is the last one to assign.
    always_comb begin
        enc_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_code[i]) begin
                enc_sel = SEL_W'(i);
            end
        end
    end

    assign enc_err   = (in_code == '0) || ((in_code & (in_code - N_IN'(1))) != '0);
    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            sel       <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                state <= FULL;
                sel   <= enc_sel;
                err   <= enc_err;
                if (enc_err && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if ((state == FULL) && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_week_4_encoder_registered.sv
// Randomized and directed bench for week_4_encoder_registered, checked against a behavioural model.
module tb_week_4_encoder_registered;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_code = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, err;
    logic [1:0] sel;
    logic [7:0] err_count;

    logic       in_ready_s, out_valid_s, err_s;
    logic [1:0] sel_s;
    logic [1:0] err_count_s;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_ov  = 0;
    int m_sel = 0;
    bit m_err = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    week_4_encoder_registered dut (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .err_count(err_count)
    );

    week_4_encoder_registered #(.ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready_s), .sel(sel_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .err(err_s), .err_count(err_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int highest_bit(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) begin
            if (c[i]) return i;
        end
        return 0;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_sel = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_ov);
        check("sel", sel, m_sel);
        check("err", err, m_err);
        check("err_count", err_count, sat(m_cnt, 255));
        check("out_valid_s", out_valid_s, m_ov);
        check("sel_s", sel_s, m_sel);
        check("err_count_s", err_count_s, sat(m_cnt, 3));
    endtask

    // Drive one cycle of stimulus, then update the model and compare after the edge.
    task automatic cycle(input logic [3:0] c, input logic v, input logic r);
        bit acc;
        in_code = c; in_valid = v; out_ready = r;
        #1;
        check("in_ready", in_ready, (!m_ov || r));
        check("in_ready_s", in_ready_s, (!m_ov || r));
        acc = v && (!m_ov || r);
        @(posedge clk);
        if (acc) begin
            m_ov  = 1;
            m_sel = highest_bit(c);
            m_err = ($countones(c) != 1);
            if (m_err) m_cnt++;
        end else if (m_ov && r) begin
            m_ov = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
    endtask

    initial begin
        int sat_exp[5] = '{1, 2, 3, 3, 3};
        #12;
        check_outputs();
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // One-hot sweep with full throughput
        cycle(4'b0001, 1, 1);
        cycle(4'b0010, 1, 1);
        cycle(4'b0100, 1, 1);
        cycle(4'b1000, 1, 1);
        cycle(4'b0000, 0, 1);

        // Backpressure: 0100 held while 1000 is refused
        cycle(4'b0100, 1, 0);
        for (int i = 0; i < 3; i++) cycle(4'b1000, 1, 0);
        check("stall_sel", sel, 2);
        cycle(4'b1000, 1, 1);
        check("after_stall_sel", sel, 3);
        cycle(4'b0000, 0, 1);

        // Illegal codes
        do_reset();
        cycle(4'b0000, 1, 1);
        cycle(4'b1010, 1, 1);
        cycle(4'b0110, 1, 1);
        check("illegal_count", err_count, 3);
        cycle(4'b0000, 0, 1);

        // Saturation of the narrow counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000, 1, 1);
            check("sat_count", err_count_s, sat_exp[i]);
        end

        // Simultaneous consume and accept: no bubble
        cycle(4'b1000, 1, 1);
        cycle(4'b0010, 1, 1);
        check("simul_valid", out_valid, 1);
        check("simul_sel", sel, 1);

        // Asynchronous reset in the middle of a stall
        cycle(4'b0000, 1, 1);
        cycle(4'b1000, 1, 0);
        cycle(4'b0100, 1, 0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
